mem_load_unit: RTL and testbench
================================

// Module: mem_load_unit
// PURPOSE
//  Multi-cycle byte-memory load sequencer feeding the 16-bit register write port.
//  Fetches two consecutive bytes over an 8-bit req/ack memory bus and assembles one 16-bit word.
//  Presents the word on reg_in with a single-cycle reg_w_flag pulse.
//  Sits directly upstream of the 16-bit register: reg_in -> in, reg_w_flag -> w_flag.
// PARAMETERS
//  ADDR_W      16  byte-address width; address arithmetic wraps mod 2^ADDR_W
//  BIG_ENDIAN  1   1: byte@A -> word[15:8], byte@A+1 -> word[7:0]; 0: swapped
//  TIMEOUT     15  max cycles waited for mem_ack per byte before abort (>=1)
// PORTS
//  clk         in   1       system clock, all state on rising edge
//  rst_n       in   1       asynchronous reset, active-low
//  ld_start    in   1       load request, sampled in IDLE only
//  ld_addr     in   ADDR_W  byte address A of word, sampled with ld_start
//  ld_busy     out  1       high in every state except IDLE
//  ld_done     out  1       1-cycle pulse, coincident with reg_w_flag
//  ld_err      out  1       1-cycle pulse on timeout abort
//  mem_req     out  1       memory read request, held until ack or timeout
//  mem_addr    out  ADDR_W  byte address of current request
//  mem_rdata   in   8       read byte, valid when mem_ack high
//  mem_ack     in   1       1-cycle acknowledge; ignored while mem_req low
//  reg_in      out  16      assembled word to register 'in'
//  reg_w_flag  out  1       1-cycle write enable to register 'w_flag'
// BEHAVIOUR
//  Reset (async, rst_n=0): state IDLE; ld_busy, ld_done, ld_err, mem_req, reg_w_flag = 0;
//   mem_addr = 0; reg_in = 16'h0000; timeout counter = 0; partial byte cleared.
//  All outputs are registered; no combinational path from inputs to outputs.
//  FSM states: IDLE, REQ0, REQ1, WRITE, ERR.
//  IDLE:  ld_start=1 -> latch A = ld_addr, mem_addr = A, mem_req = 1, goto REQ0.
//  REQ0:  mem_ack=1 -> capture byte0; mem_addr = A+1 (wraps); mem_req stays 1; goto REQ1.
//  REQ1:  mem_ack=1 -> capture byte1, assemble word per BIG_ENDIAN, mem_req = 0; goto WRITE.
//  WRITE: reg_w_flag = 1 and ld_done = 1 for exactly this cycle; reg_in = word; goto IDLE.
//  ERR:   ld_err = 1 for exactly one cycle, mem_req = 0, no write; goto IDLE.
//  Ack timing: mem_ack is accepted in any cycle of REQ0/REQ1, including the first.
//  Timeout: counter clears on entry to REQ0/REQ1 and increments each cycle without ack.
//   When TIMEOUT cycles have elapsed with no ack -> ERR; bytes already captured are discarded.
//  reg_in changes only on a successful WRITE and holds its value otherwise.
//   A register holding w_flag=0 therefore sees a stable in.
//  Latency: with immediate ack, the ld_start sampling edge is followed by 3 edges to WRITE.
//   ld_start cycle = 0, reg_w_flag high in cycle 3; back-to-back load accepted in cycle 4.
//  ld_start while ld_busy=1 (incl. WRITE/ERR) is ignored, not queued.
//  mem_ack while mem_req=0 is ignored.
//  Address wrap: A = 2^ADDR_W-1 -> second byte fetched from address 0.
//  Reset mid-operation: immediate abort to reset values; no reg_w_flag, ld_done or ld_err pulse.
// TESTING
//  1. BIG_ENDIAN=1, A=16'h0100, bytes AA then 55, ack on first req cycle
//     -> reg_w_flag 1 cycle at cycle 3, reg_in=16'hAA55, ld_done coincident.
//  2. BIG_ENDIAN=0, bytes 00 then FF, ack after 4 wait cycles each
//     -> reg_in=16'hFF00, ld_busy high 11 cycles, single write pulse.
//  3. Memory never acks REQ1, TIMEOUT=15
//     -> ld_err pulse after 15 wait cycles; no reg_w_flag; reg_in keeps prior value 16'hFF00.
//  4. ld_start pulsed in REQ0 and in WRITE with a new address
//     -> ignored; mem_addr sequence A, A+1 only; exactly one write.
//  5. A=16'hFFFF -> mem_addr 16'hFFFF then 16'h0000; word assembled correctly.
//  6. rst_n low during REQ1 -> all outputs 0 immediately; no write; next load from IDLE works.

Source files
------------

// File: rtl/mem_load_unit.sv
// mem_load_unit: two-byte load sequencer over an 8-bit req/ack memory bus.
// Fetches bytes at A and A+1, assembles a 16-bit word and presents it to the
// downstream register with a single-cycle write pulse. All outputs registered.
module mem_load_unit #(
  parameter int unsigned ADDR_W     = 16,
  parameter bit          BIG_ENDIAN = 1'b1,
  parameter int unsigned TIMEOUT    = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ld_start,
  input  logic [ADDR_W-1:0] ld_addr,
  output logic              ld_busy,
  output logic              ld_done,
  output logic              ld_err,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_rdata,
  input  logic              mem_ack,
  output logic [15:0]       reg_in,
  output logic              reg_w_flag
);

  // Wait counter only has to reach TIMEOUT-1 before the abort decision.
  localparam int unsigned     CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE,
    REQ0,
    REQ1,
    WRITE,
    ERR
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] wait_cnt;
  logic [7:0]       byte0;
  logic [15:0]      word;

  // Byte placement depends on the configured endianness.
  always_comb begin
    word = BIG_ENDIAN ? {byte0, mem_rdata} : {mem_rdata, byte0};
  end

  // Load sequencer: state, bus request, timeout and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      wait_cnt   <= '0;
      byte0      <= '0;
      ld_busy    <= 1'b0;
      ld_done    <= 1'b0;
      ld_err     <= 1'b0;
      mem_req    <= 1'b0;
      mem_addr   <= '0;
      reg_in     <= '0;
      reg_w_flag <= 1'b0;
    end else begin
      ld_done    <= 1'b0;
      ld_err     <= 1'b0;
      reg_w_flag <= 1'b0;
      case (state)
        IDLE: begin
          if (ld_start) begin
            mem_addr <= ld_addr;
            mem_req  <= 1'b1;
            ld_busy  <= 1'b1;
            wait_cnt <= '0;
            state    <= REQ0;
          end
        end
        REQ0: begin
          if (mem_ack) begin
            byte0    <= mem_rdata;
            mem_addr <= mem_addr + ADDR_W'(1);
            wait_cnt <= '0;
            state    <= REQ1;
          end else if (wait_cnt == CNT_LAST) begin
            mem_req <= 1'b0;
            ld_err  <= 1'b1;
            byte0   <= '0;
            state   <= ERR;
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
        end
        REQ1: begin
          if (mem_ack) begin
            reg_in     <= word;
            reg_w_flag <= 1'b1;
            ld_done    <= 1'b1;
            mem_req    <= 1'b0;
            byte0      <= '0;
            state      <= WRITE;
          end else if (wait_cnt == CNT_LAST) begin
            mem_req <= 1'b0;
            ld_err  <= 1'b1;
            byte0   <= '0;
            state   <= ERR;
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
        end
        WRITE, ERR: begin
          ld_busy <= 1'b0;
          state   <= IDLE;
        end
        default: begin
          ld_busy <= 1'b0;
          mem_req <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_load_unit.sv
// Testbench for mem_load_unit: big- and little-endian instances share stimulus;
// expected words are queued per load and checked on each write pulse.
module tb_mem_load_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ld_start;
  logic [15:0] ld_addr;
  logic [7:0]  mem_rdata;
  logic        mem_ack;

  logic        ld_busy_be, ld_done_be, ld_err_be, mem_req_be, reg_w_flag_be;
  logic [15:0] mem_addr_be, reg_in_be;
  logic        ld_busy_le, ld_done_le, ld_err_le, mem_req_le, reg_w_flag_le;
  logic [15:0] mem_addr_le, reg_in_le;

  always #5 clk = ~clk;

  mem_load_unit #(.ADDR_W(16), .BIG_ENDIAN(1'b1), .TIMEOUT(15)) u_be (
    .clk(clk), .rst_n(rst_n), .ld_start(ld_start), .ld_addr(ld_addr),
    .ld_busy(ld_busy_be), .ld_done(ld_done_be), .ld_err(ld_err_be),
    .mem_req(mem_req_be), .mem_addr(mem_addr_be), .mem_rdata(mem_rdata),
    .mem_ack(mem_ack), .reg_in(reg_in_be), .reg_w_flag(reg_w_flag_be)
  );

  mem_load_unit #(.ADDR_W(16), .BIG_ENDIAN(1'b0), .TIMEOUT(15)) u_le (
    .clk(clk), .rst_n(rst_n), .ld_start(ld_start), .ld_addr(ld_addr),
    .ld_busy(ld_busy_le), .ld_done(ld_done_le), .ld_err(ld_err_le),
    .mem_req(mem_req_le), .mem_addr(mem_addr_le), .mem_rdata(mem_rdata),
    .mem_ack(mem_ack), .reg_in(reg_in_le), .reg_w_flag(reg_w_flag_le)
  );

  typedef struct {
    logic [15:0] be;
    logic [15:0] le;
  } exp_t;

  typedef struct {
    logic [15:0] addr;
    logic [7:0]  b0;
    logic [7:0]  b1;
    int unsigned w0;
    int unsigned w1;
    logic [15:0] exp_be;
    logic [15:0] exp_le;
  } vec_t;

  exp_t        sb_q[$];
  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  logic [15:0] last_be = '0;
  logic [15:0] last_le = '0;
  int unsigned busy_run = 0;
  int unsigned busy_len = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  // Scoreboard and hold checks at every falling edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      last_be  = '0;
      last_le  = '0;
      busy_run = 0;
    end else begin
      if (ld_busy_be) begin
        busy_run++;
      end else if (busy_run != 0) begin
        busy_len = busy_run;
        busy_run = 0;
      end
      if (reg_w_flag_be) begin
        chk("flag_le", {31'd0, reg_w_flag_le}, 32'd1);
        if (sb_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_write: got reg_in %h with no load pending", reg_in_be);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          chk("word_be", reg_in_be, e.be);
          chk("word_le", reg_in_le, e.le);
          last_be = e.be;
          last_le = e.le;
        end
      end else begin
        chk("flag_le_idle", {31'd0, reg_w_flag_le}, 32'd0);
        chk("hold_be", reg_in_be, last_be);
        chk("hold_le", reg_in_le, last_le);
      end
    end
  end

  task automatic do_load(input logic [15:0] a, input logic [7:0] b0, input logic [7:0] b1,
                         input int unsigned w0, input int unsigned w1,
                         input logic [15:0] ebe, input logic [15:0] ele, input bit poke);
    logic [15:0] a1;
    a1 = a + 16'd1;
    sb_q.push_back('{ebe, ele});
    ld_addr  = a;
    ld_start = 1'b1;
    step();
    ld_start = 1'b0;
    ld_addr  = ~a;
    for (int unsigned i = 0; i < w0; i++) begin
      chk("req0_req", {31'd0, mem_req_be}, 32'd1);
      chk("req0_addr", mem_addr_be, a);
      if (poke && i == 0) begin
        ld_start = 1'b1;
        ld_addr  = a ^ 16'h5555;
      end
      step();
      ld_start = 1'b0;
    end
    chk("req0_addr", mem_addr_be, a);
    chk("req0_busy", {31'd0, ld_busy_be}, 32'd1);
    mem_ack   = 1'b1;
    mem_rdata = b0;
    step();
    mem_ack   = 1'b0;
    mem_rdata = 8'($urandom);
    for (int unsigned i = 0; i < w1; i++) begin
      chk("req1_req", {31'd0, mem_req_be}, 32'd1);
      chk("req1_addr", mem_addr_be, a1);
      step();
    end
    chk("req1_addr", mem_addr_be, a1);
    chk("req1_addr_le", mem_addr_le, a1);
    mem_ack   = 1'b1;
    mem_rdata = b1;
    step();
    mem_ack   = 1'b0;
    mem_rdata = 8'($urandom);
    chk("write_flag", {31'd0, reg_w_flag_be}, 32'd1);
    chk("write_done", {31'd0, ld_done_be}, 32'd1);
    chk("write_req", {31'd0, mem_req_be}, 32'd0);
    chk("write_busy", {31'd0, ld_busy_be}, 32'd1);
    if (poke) begin
      ld_start = 1'b1;
      ld_addr  = a ^ 16'hAAAA;
    end
    step();
    ld_start = 1'b0;
    chk("idle_busy", {31'd0, ld_busy_be}, 32'd0);
    chk("idle_req", {31'd0, mem_req_be}, 32'd0);
    chk("idle_done", {31'd0, ld_done_be}, 32'd0);
    chk("busy_len", busy_len, w0 + w1 + 3);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[6];
    vecs[0] = '{16'h0100, 8'hAA, 8'h55, 0,  0,  16'hAA55, 16'h55AA};
    vecs[1] = '{16'h1234, 8'h12, 8'h34, 1,  0,  16'h1234, 16'h3412};
    vecs[2] = '{16'h8000, 8'h5A, 8'hC3, 0,  2,  16'h5AC3, 16'hC35A};
    vecs[3] = '{16'hFFFF, 8'h0F, 8'hF0, 0,  0,  16'h0FF0, 16'hF00F};
    vecs[4] = '{16'h00FE, 8'h80, 8'h01, 14, 14, 16'h8001, 16'h0180};
    vecs[5] = '{16'h4000, 8'h00, 8'hFF, 4,  4,  16'h00FF, 16'hFF00};

    rst_n     = 1'b0;
    ld_start  = 1'b0;
    ld_addr   = '0;
    mem_rdata = '0;
    mem_ack   = 1'b0;
    step();
    step();
    chk("rst_busy", {31'd0, ld_busy_be}, 32'd0);
    chk("rst_req", {31'd0, mem_req_be}, 32'd0);
    chk("rst_addr", mem_addr_be, 32'd0);
    chk("rst_reg_in", reg_in_be, 32'd0);
    chk("rst_flag", {31'd0, reg_w_flag_be}, 32'd0);
    chk("rst_err", {31'd0, ld_err_be}, 32'd0);
    rst_n = 1'b1;
    step();

    // Ack while idle has no effect.
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    chk("idle_ack_busy", {31'd0, ld_busy_be}, 32'd0);
    chk("idle_ack_req", {31'd0, mem_req_be}, 32'd0);

    for (int i = 0; i < 6; i++) begin
      do_load(vecs[i].addr, vecs[i].b0, vecs[i].b1, vecs[i].w0, vecs[i].w1,
              vecs[i].exp_be, vecs[i].exp_le, 1'b0);
    end

    // Second byte never acknowledged: abort after 15 waits, word kept.
    ld_addr  = 16'h2000;
    ld_start = 1'b1;
    step();
    ld_start  = 1'b0;
    mem_ack   = 1'b1;
    mem_rdata = 8'h77;
    step();
    mem_ack = 1'b0;
    for (int i = 0; i < 15; i++) begin
      chk("to_req", {31'd0, mem_req_be}, 32'd1);
      chk("to_err_early", {31'd0, ld_err_be}, 32'd0);
      chk("to_addr", mem_addr_be, 32'h2001);
      step();
    end
    chk("to_err", {31'd0, ld_err_be}, 32'd1);
    chk("to_err_le", {31'd0, ld_err_le}, 32'd1);
    chk("to_req_low", {31'd0, mem_req_be}, 32'd0);
    chk("to_no_flag", {31'd0, reg_w_flag_be}, 32'd0);
    chk("to_busy", {31'd0, ld_busy_be}, 32'd1);
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    chk("to_err_clear", {31'd0, ld_err_be}, 32'd0);
    chk("to_idle", {31'd0, ld_busy_be}, 32'd0);
    chk("to_keep_le", reg_in_le, 32'h0000FF00);

    // Start requests while busy are ignored.
    do_load(16'h3000, 8'hC0, 8'hDE, 2, 1, 16'hC0DE, 16'hDEC0, 1'b1);

    // Reset during the second fetch aborts without any pulse.
    ld_addr  = 16'h5000;
    ld_start = 1'b1;
    step();
    ld_start  = 1'b0;
    mem_ack   = 1'b1;
    mem_rdata = 8'h99;
    step();
    mem_ack = 1'b0;
    chk("mid_req1", {31'd0, mem_req_be}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_busy", {31'd0, ld_busy_be}, 32'd0);
    chk("mid_req", {31'd0, mem_req_be}, 32'd0);
    chk("mid_addr", mem_addr_be, 32'd0);
    chk("mid_reg_in", reg_in_be, 32'd0);
    chk("mid_flag", {31'd0, reg_w_flag_be}, 32'd0);
    chk("mid_done", {31'd0, ld_done_be}, 32'd0);
    chk("mid_err", {31'd0, ld_err_be}, 32'd0);
    step();
    rst_n = 1'b1;
    step();
    chk("post_rst_busy", {31'd0, ld_busy_be}, 32'd0);
    do_load(16'h6000, 8'h12, 8'hEF, 0, 0, 16'h12EF, 16'hEF12, 1'b0);

    step();
    chk("sb_empty", sb_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
